lab3_checker: RTL and testbench
===============================

# lab3_checker

Response checker that sits directly downstream of the lab 3 six-input stimulus generator and the combinational circuit under test. On each sample strobe it captures the applied vector {a,b,c,d,e,f} and the circuit output y, and compares y against a parameterised 64-entry truth table. It also verifies that vectors arrive in the generator's descending order, compacts all responses into a signature and reports a pass/fail verdict after 64 samples.

## Interface
- TRUTH, 64'h0: expected y per vector index; bit i is the expected output for vector value i.
- NVEC, 64: samples per run; fixed at 64, the full 6-bit space.
- POLY, 16'h8005: feedback polynomial for the signature LFSR.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins or restarts a run.
- sample  input  1  one-cycle strobe: the current a..f and y are valid.
- a, b, c, d, e, f  input  1 each  applied vector; a is the MSB, f is the LSB.
- y  input  1  circuit-under-test output.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  valid when done is high: err_cnt==0 and order_err==0.
- err_cnt  output  7  count of output mismatches (range 0..64).
- order_err  output  1  sticky: a vector arrived out of descending order.
- first_fail  output  6  vector index of the first mismatch.
- first_fail_vld  output  1  first_fail holds a captured value.
- signature  output  16  LFSR compaction of the y stream.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE -> RUN on start. The same transition clears err_cnt, order_err, first_fail, first_fail_vld and the sample counter, sets signature to 16'hFFFF and sets exp_vec to 63.
- In RUN, each sample does the following, with vec={a,b,c,d,e,f}:
  - Compute the mismatch as y != TRUTH[vec]. On a mismatch, err_cnt += 1. On the first mismatch only, first_fail <= vec and first_fail_vld <= 1.
  - If vec != exp_vec, set order_err <= 1. exp_vec <= exp_vec - 1, wrapping 0 -> 63. The decrement follows the expected sequence, not the received vector.
  - Update signature: sig <= {sig[14:0],1'b0} ^ ((sig[15]^y) ? POLY : 16'h0).
  - Increment the sample counter (7 bits). When the counter reaches 64, move RUN -> DONE.
- DONE holds all results until the next start, then behaves as IDLE -> RUN.
- sample is ignored in IDLE and DONE.
- A start in RUN restarts the run: everything is cleared exactly as on IDLE -> RUN.
- err_cnt cannot exceed 64 within a run, so no saturation logic is needed.

## Timing
- All outputs are registered and update on the rising edge that samples the strobe. They are visible in the following cycle.
- Reset values: busy=0, done=0, pass=0, err_cnt=0, order_err=0, first_fail=0, first_fail_vld=0, signature=16'hFFFF.
- Latency from the 64th sample edge to done=1 is one cycle. pass is valid in the same cycle as done.
- start and sample in the same cycle: start wins and the sample is discarded, in any state.
- Back-to-back samples, one per cycle, are supported. There is no minimum gap.
- Asserting rst mid-run immediately forces IDLE and the reset values, with no partial verdict.
- pass is combinationally derived from registered state, gated by done.

## Structure
- A shared package lab3_pkg holds the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the NVEC constant, the default POLY and the signature seed 16'hFFFF.
- One sub-module, lab3_sig_lfsr, is the 16-bit serial-input signature register. Its ports are clk, rst, clr, en, din and sig, with POLY as a parameter.
- The top level contains the FSM, the counters, the order check and the first-fail capture.

## Test plan
- Golden run: TRUTH=64'hF0F0_0F0F_AAAA_5555. Drive vectors 63..0 with y=TRUTH[vec], one sample per cycle. Required: done one cycle after the 64th sample, pass=1, err_cnt=0, order_err=0, first_fail_vld=0, and signature equal to the bench model's value.
- Injected faults: same as the golden run, but invert y at vectors 40 and 7. Required: err_cnt=2, first_fail=40, first_fail_vld=1, pass=0, order_err=0.
- Order violation: swap vectors 10 and 9 in the sequence, with y correct. Required: order_err=1, err_cnt=0, pass=0.
- Restart: after 20 samples, pulse start together with sample. Required: the sample is discarded, counters clear, and a following full golden run gives pass=1.
- Reset mid-run: assert rst after 30 samples. Required: all outputs return to reset values asynchronously, the state is IDLE, and samples are ignored until start.
- Idle strobes: samples before any start. Required: no change to any output and done stays 0.

Source files
------------

// File: rtl/lab3_pkg.sv
// Shared constants for the lab 3 response checker: FSM encoding, run length,
// default signature polynomial and seed.
package lab3_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int          NVEC_DEF = 64;
  localparam logic [15:0] POLY_DEF = 16'h8005;
  localparam logic [15:0] SIG_SEED = 16'hFFFF;

  // a is the MSB of the applied vector, f the LSB
  function automatic logic [5:0] packVec(input logic a, input logic b, input logic c,
                                         input logic d, input logic e, input logic f);
    return {a, b, c, d, e, f};
  endfunction

endpackage

// File: rtl/lab3_checker_if.sv
// Strobe, vector and verdict signals between the stimulus side and the checker.
interface lab3_checker_if;

  logic        start;
  logic        sample;
  logic        a, b, c, d, e, f;
  logic        y;
  logic        busy;
  logic        done;
  logic        pass;
  logic [6:0]  err_cnt;
  logic        order_err;
  logic [5:0]  first_fail;
  logic        first_fail_vld;
  logic [15:0] signature;

  modport master (
    output start, sample, a, b, c, d, e, f, y,
    input  busy, done, pass, err_cnt, order_err, first_fail, first_fail_vld, signature
  );

  modport slave (
    input  start, sample, a, b, c, d, e, f, y,
    output busy, done, pass, err_cnt, order_err, first_fail, first_fail_vld, signature
  );

endinterface

// File: rtl/lab3_sig_lfsr.sv
// 16-bit serial-input signature register compacting the y stream of a run.
module lab3_sig_lfsr
  import lab3_pkg::*;
#(
  parameter logic [15:0] POLY = POLY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] sig
);

  // clr has priority so a restart coinciding with a strobe reseeds cleanly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= SIG_SEED;
    end else if (clr) begin
      sig <= SIG_SEED;
    end else if (en) begin
      sig <= {sig[14:0], 1'b0} ^ ((sig[15] ^ din) ? POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/lab3_checker.sv
// Lab 3 response checker: compares y against a truth table, checks descending
// vector order, compacts responses and reports a verdict after NVEC samples.
module lab3_checker
  import lab3_pkg::*;
#(
  parameter logic [63:0] TRUTH = 64'h0,
  parameter int          NVEC  = NVEC_DEF,
  parameter logic [15:0] POLY  = POLY_DEF
) (
  input  logic          clk,
  input  logic          rst,
  lab3_checker_if.slave bus
);

  logic [1:0]  r_state;
  logic [6:0]  r_cnt;
  logic [6:0]  r_err;
  logic [5:0]  r_exp;
  logic [5:0]  r_ff;
  logic        r_ffv;
  logic        r_ord;

  logic [5:0]  w_vec;
  logic        w_accept;
  logic        w_mis;
  logic        w_last;
  logic [15:0] w_sig;

  assign w_vec    = packVec(bus.a, bus.b, bus.c, bus.d, bus.e, bus.f);
  assign w_accept = bus.sample && !bus.start && (r_state == ST_RUN);
  assign w_mis    = (bus.y != TRUTH[w_vec]);
  assign w_last   = (r_cnt == 7'(NVEC - 1));

  lab3_sig_lfsr #(.POLY(POLY)) u_sig (
    .clk (clk),
    .rst (rst),
    .clr (bus.start),
    .en  (w_accept),
    .din (bus.y),
    .sig (w_sig)
  );

  // start restarts from any state; r_exp decrements along the expected
  // sequence and wraps naturally at 6 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 7'd0;
      r_err   <= 7'd0;
      r_exp   <= 6'd63;
      r_ff    <= 6'd0;
      r_ffv   <= 1'b0;
      r_ord   <= 1'b0;
    end else if (bus.start) begin
      r_state <= ST_RUN;
      r_cnt   <= 7'd0;
      r_err   <= 7'd0;
      r_exp   <= 6'd63;
      r_ff    <= 6'd0;
      r_ffv   <= 1'b0;
      r_ord   <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 7'd1;
      r_exp <= r_exp - 6'd1;
      if (w_mis) begin
        r_err <= r_err + 7'd1;
        if (!r_ffv) begin
          r_ff  <= w_vec;
          r_ffv <= 1'b1;
        end
      end
      if (w_vec != r_exp) begin
        r_ord <= 1'b1;
      end
      if (w_last) begin
        r_state <= ST_DONE;
      end
    end
  end

  assign bus.busy           = (r_state == ST_RUN);
  assign bus.done           = (r_state == ST_DONE);
  assign bus.pass           = (r_state == ST_DONE) && (r_err == 7'd0) && !r_ord;
  assign bus.err_cnt        = r_err;
  assign bus.order_err      = r_ord;
  assign bus.first_fail     = r_ff;
  assign bus.first_fail_vld = r_ffv;
  assign bus.signature      = w_sig;

endmodule

// File: tb/tb_lab3_checker.sv
// Self-checking bench for lab3_checker: randomized runs compared against a
// behavioural model of the verdict, order check and signature.
module tb_lab3_checker;

  localparam logic [63:0] TRUTH = 64'hF0F0_0F0F_AAAA_5555;
  localparam logic [15:0] POLY  = 16'h8005;

  logic clk = 1'b0;
  logic rst;
  int   nChecks = 0;
  int   nPassed = 0;

  logic [5:0]  qVec[$];
  logic        qY[$];
  logic [6:0]  expErr;
  logic [5:0]  expFF;
  logic        expFFV;
  logic        expOrd;
  logic        expPass;
  logic [15:0] expSig;

  lab3_checker_if bus();

  lab3_checker #(.TRUTH(TRUTH), .NVEC(64), .POLY(POLY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic setVec(input logic [5:0] v, input logic yv);
    {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f} = v;
    bus.y = yv;
  endtask

  task automatic buildGolden();
    qVec.delete();
    qY.delete();
    for (int i = 63; i >= 0; i--) begin
      qVec.push_back(6'(i));
      qY.push_back(TRUTH[i]);
    end
  endtask

  // expected results straight from the checking rules over the whole stream
  task automatic modelRun();
    logic [15:0] s;
    logic [5:0]  v;
    expErr = 0; expFF = 0; expFFV = 0; expOrd = 0; s = 16'hFFFF;
    for (int k = 0; k < qVec.size(); k++) begin
      v = qVec[k];
      if (qY[k] != TRUTH[v]) begin
        expErr = expErr + 7'd1;
        if (!expFFV) begin
          expFF  = v;
          expFFV = 1'b1;
        end
      end
      if (int'(v) != 63 - k) expOrd = 1'b1;
      s = {s[14:0], 1'b0} ^ ((s[15] ^ qY[k]) ? POLY : 16'h0000);
    end
    expSig  = s;
    expPass = (expErr == 0) && !expOrd;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic driveQueue(input int n, input int gapMax);
    int gaps;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.sample = 1'b1;
      setVec(qVec[k], qY[k]);
      gaps = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
      if (gaps > 0) begin
        @(negedge clk);
        bus.sample = 1'b0;
        setVec(6'($urandom), 1'($urandom));
        repeat (gaps - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    bus.sample = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.sample = 0; setVec(6'd0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nChecks += 8;
    if (bus.busy !== 1'b0) $display("[TB] FAIL rst_busy got %b want 0", bus.busy); else nPassed++;
    if (bus.done !== 1'b0) $display("[TB] FAIL rst_done got %b want 0", bus.done); else nPassed++;
    if (bus.pass !== 1'b0) $display("[TB] FAIL rst_pass got %b want 0", bus.pass); else nPassed++;
    if (bus.err_cnt !== 7'd0) $display("[TB] FAIL rst_err got %0d want 0", bus.err_cnt); else nPassed++;
    if (bus.order_err !== 1'b0) $display("[TB] FAIL rst_order got %b want 0", bus.order_err); else nPassed++;
    if (bus.first_fail !== 6'd0) $display("[TB] FAIL rst_ff got %0d want 0", bus.first_fail); else nPassed++;
    if (bus.first_fail_vld !== 1'b0) $display("[TB] FAIL rst_ffv got %b want 0", bus.first_fail_vld); else nPassed++;
    if (bus.signature !== 16'hFFFF) $display("[TB] FAIL rst_sig got %h want FFFF", bus.signature); else nPassed++;
    rst = 1'b0;
  endtask

  task automatic test_idle_strobes();
    qVec.delete(); qY.delete();
    for (int k = 0; k < 12; k++) begin
      qVec.push_back(6'($urandom));
      qY.push_back(1'($urandom));
    end
    driveQueue(12, 0);
    nChecks += 5;
    if (bus.done !== 1'b0) $display("[TB] FAIL idle_done got %b want 0", bus.done); else nPassed++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL idle_busy got %b want 0", bus.busy); else nPassed++;
    if (bus.err_cnt !== 7'd0) $display("[TB] FAIL idle_err got %0d want 0", bus.err_cnt); else nPassed++;
    if (bus.first_fail_vld !== 1'b0) $display("[TB] FAIL idle_ffv got %b want 0", bus.first_fail_vld); else nPassed++;
    if (bus.signature !== 16'hFFFF) $display("[TB] FAIL idle_sig got %h want FFFF", bus.signature); else nPassed++;
  endtask

  task automatic test_golden();
    buildGolden();
    modelRun();
    pulseStart();
    nChecks += 3;
    if (bus.busy !== 1'b1) $display("[TB] FAIL gold_busy got %b want 1", bus.busy); else nPassed++;
    if (bus.pass !== 1'b0) $display("[TB] FAIL gold_pass_early got %b want 0", bus.pass); else nPassed++;
    if (bus.done !== 1'b0) $display("[TB] FAIL gold_done_early got %b want 0", bus.done); else nPassed++;
    driveQueue(64, 0);
    nChecks += 7;
    if (bus.done !== 1'b1) $display("[TB] FAIL gold_done got %b want 1", bus.done); else nPassed++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL gold_busy_end got %b want 0", bus.busy); else nPassed++;
    if (bus.pass !== 1'b1) $display("[TB] FAIL gold_pass got %b want 1", bus.pass); else nPassed++;
    if (bus.err_cnt !== 7'd0) $display("[TB] FAIL gold_err got %0d want 0", bus.err_cnt); else nPassed++;
    if (bus.order_err !== 1'b0) $display("[TB] FAIL gold_order got %b want 0", bus.order_err); else nPassed++;
    if (bus.first_fail_vld !== 1'b0) $display("[TB] FAIL gold_ffv got %b want 0", bus.first_fail_vld); else nPassed++;
    if (bus.signature !== expSig) $display("[TB] FAIL gold_sig got %h want %h", bus.signature, expSig); else nPassed++;
  endtask

  task automatic test_faults();
    buildGolden();
    qY[63 - 40] = ~qY[63 - 40];
    qY[63 - 7]  = ~qY[63 - 7];
    modelRun();
    pulseStart();
    driveQueue(64, 0);
    nChecks += 7;
    if (bus.err_cnt !== 7'd2) $display("[TB] FAIL flt_err got %0d want 2", bus.err_cnt); else nPassed++;
    if (bus.first_fail !== 6'd40) $display("[TB] FAIL flt_ff got %0d want 40", bus.first_fail); else nPassed++;
    if (bus.first_fail_vld !== 1'b1) $display("[TB] FAIL flt_ffv got %b want 1", bus.first_fail_vld); else nPassed++;
    if (bus.pass !== 1'b0) $display("[TB] FAIL flt_pass got %b want 0", bus.pass); else nPassed++;
    if (bus.order_err !== 1'b0) $display("[TB] FAIL flt_order got %b want 0", bus.order_err); else nPassed++;
    if (bus.done !== 1'b1) $display("[TB] FAIL flt_done got %b want 1", bus.done); else nPassed++;
    if (bus.signature !== expSig) $display("[TB] FAIL flt_sig got %h want %h", bus.signature, expSig); else nPassed++;
  endtask

  task automatic test_order();
    buildGolden();
    qVec[53] = 6'd9;  qY[53] = TRUTH[9];
    qVec[54] = 6'd10; qY[54] = TRUTH[10];
    modelRun();
    pulseStart();
    driveQueue(64, 0);
    nChecks += 4;
    if (bus.order_err !== 1'b1) $display("[TB] FAIL ord_order got %b want 1", bus.order_err); else nPassed++;
    if (bus.err_cnt !== 7'd0) $display("[TB] FAIL ord_err got %0d want 0", bus.err_cnt); else nPassed++;
    if (bus.pass !== 1'b0) $display("[TB] FAIL ord_pass got %b want 0", bus.pass); else nPassed++;
    if (bus.signature !== expSig) $display("[TB] FAIL ord_sig got %h want %h", bus.signature, expSig); else nPassed++;
  endtask

  task automatic test_random(input int iter);
    int i;
    buildGolden();
    for (int k = 0; k < 64; k++) begin
      if ($urandom_range(7, 0) == 0) qY[k] = ~qY[k];
    end
    if ($urandom_range(1, 0) == 1) begin
      i = int'($urandom_range(62, 0));
      qVec[i] = qVec[i + 1];
      qY[i]   = 1'($urandom);
    end
    modelRun();
    pulseStart();
    driveQueue(64, 3);
    nChecks += 7;
    if (bus.done !== 1'b1) $display("[TB] FAIL rnd%0d_done got %b want 1", iter, bus.done); else nPassed++;
    if (bus.err_cnt !== expErr) $display("[TB] FAIL rnd%0d_err got %0d want %0d", iter, bus.err_cnt, expErr); else nPassed++;
    if (bus.first_fail_vld !== expFFV) $display("[TB] FAIL rnd%0d_ffv got %b want %b", iter, bus.first_fail_vld, expFFV); else nPassed++;
    if (bus.first_fail !== expFF) $display("[TB] FAIL rnd%0d_ff got %0d want %0d", iter, bus.first_fail, expFF); else nPassed++;
    if (bus.order_err !== expOrd) $display("[TB] FAIL rnd%0d_order got %b want %b", iter, bus.order_err, expOrd); else nPassed++;
    if (bus.pass !== expPass) $display("[TB] FAIL rnd%0d_pass got %b want %b", iter, bus.pass, expPass); else nPassed++;
    if (bus.signature !== expSig) $display("[TB] FAIL rnd%0d_sig got %h want %h", iter, bus.signature, expSig); else nPassed++;
  endtask

  task automatic test_restart();
    buildGolden();
    for (int k = 0; k < 20; k++) qY[k] = 1'($urandom);
    pulseStart();
    driveQueue(20, 0);
    @(negedge clk);
    bus.start = 1'b1; bus.sample = 1'b1;
    setVec(6'd63, ~TRUTH[63]);
    @(negedge clk);
    bus.start = 1'b0; bus.sample = 1'b0;
    nChecks += 5;
    if (bus.busy !== 1'b1) $display("[TB] FAIL rs_busy got %b want 1", bus.busy); else nPassed++;
    if (bus.err_cnt !== 7'd0) $display("[TB] FAIL rs_err got %0d want 0", bus.err_cnt); else nPassed++;
    if (bus.first_fail_vld !== 1'b0) $display("[TB] FAIL rs_ffv got %b want 0", bus.first_fail_vld); else nPassed++;
    if (bus.order_err !== 1'b0) $display("[TB] FAIL rs_order got %b want 0", bus.order_err); else nPassed++;
    if (bus.signature !== 16'hFFFF) $display("[TB] FAIL rs_sig got %h want FFFF", bus.signature); else nPassed++;
    buildGolden();
    modelRun();
    driveQueue(64, 0);
    nChecks += 3;
    if (bus.done !== 1'b1) $display("[TB] FAIL rs_done got %b want 1", bus.done); else nPassed++;
    if (bus.pass !== 1'b1) $display("[TB] FAIL rs_pass got %b want 1", bus.pass); else nPassed++;
    if (bus.signature !== expSig) $display("[TB] FAIL rs_gold_sig got %h want %h", bus.signature, expSig); else nPassed++;
  endtask

  task automatic test_reset_midrun();
    buildGolden();
    qY[63 - 60] = ~qY[63 - 60];
    pulseStart();
    driveQueue(30, 0);
    #1 rst = 1'b1;
    #1;
    nChecks += 5;
    if (bus.busy !== 1'b0) $display("[TB] FAIL mr_busy got %b want 0", bus.busy); else nPassed++;
    if (bus.done !== 1'b0) $display("[TB] FAIL mr_done got %b want 0", bus.done); else nPassed++;
    if (bus.err_cnt !== 7'd0) $display("[TB] FAIL mr_err got %0d want 0", bus.err_cnt); else nPassed++;
    if (bus.first_fail_vld !== 1'b0) $display("[TB] FAIL mr_ffv got %b want 0", bus.first_fail_vld); else nPassed++;
    if (bus.signature !== 16'hFFFF) $display("[TB] FAIL mr_sig got %h want FFFF", bus.signature); else nPassed++;
    @(negedge clk);
    rst = 1'b0;
    driveQueue(5, 0);
    nChecks += 3;
    if (bus.busy !== 1'b0) $display("[TB] FAIL mr_idle_busy got %b want 0", bus.busy); else nPassed++;
    if (bus.err_cnt !== 7'd0) $display("[TB] FAIL mr_idle_err got %0d want 0", bus.err_cnt); else nPassed++;
    if (bus.signature !== 16'hFFFF) $display("[TB] FAIL mr_idle_sig got %h want FFFF", bus.signature); else nPassed++;
  endtask

  initial begin
    test_reset();
    test_idle_strobes();
    test_golden();
    test_faults();
    test_order();
    for (int n = 0; n < 6; n++) test_random(n);
    test_restart();
    test_reset_midrun();
    test_golden();
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
